// File: rtl/ahb_reg_slave_if.sv
// AHB-Lite slave-side bus bundle for the register block.
// Master drives the address/control/write-data signals; slave returns data and response.
interface ahb_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel_x;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready_in;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport master (
        output hsel_x, haddr, htrans, hwrite, hsize, hwdata, hready_in,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel_x, haddr, htrans, hwrite, hsize, hwdata, hready_in,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_reg_slave.sv
// AHB-Lite register bank: RW registers with byte-lane writes, RO registers mirrored from reg_d.
// Latency: zero-wait OKAY; errors give the two-cycle ERROR response (one wait state).
// Backpressure: hreadyout drops only in the first ERROR cycle; address phases seen then are dropped.
module ahb_reg_slave #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK    = NUM_REGS'('b0001)
) (
    input  logic                           hclk,
    input  logic                           hresetn,
    ahb_reg_slave_if.slave                 bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int OW = $clog2(BW);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Pending data phase of the last accepted, error-free transfer
    logic                  dp_wr;
    logic                  dp_rd;
    logic [IW-1:0]         dp_idx;
    logic [2:0]            dp_off;
    logic [2:0]            dp_size;

    logic [ADDR_WIDTH-1:0] a_idx;
    logic [2:0]            a_off;
    logic                  idx_ok;
    logic                  size_ok;
    logic                  align_ok;
    logic                  ro_hit;
    logic                  a_err;
    logic                  capture;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign a_idx    = bus.haddr >> OW;
    assign a_off    = 3'(bus.haddr & ADDR_WIDTH'(BW - 1));
    assign idx_ok   = (32'(a_idx) < NUM_REGS);
    assign size_ok  = (bus.hsize <= 3'(OW));
    assign align_ok = ((a_off & ((3'd1 << bus.hsize) - 3'd1)) == 3'd0);
    assign ro_hit   = idx_ok && RO_MASK[a_idx[IW-1:0]];
    assign a_err    = !idx_ok || !size_ok || !align_ok || (bus.hwrite && ro_hit);
    assign capture  = bus.hsel_x && bus.hready_in && bus.htrans[1] && (state != ST_ERR1);

    assign bus.hreadyout = (state != ST_ERR1);
    assign bus.hresp     = (state != ST_OKAY);

    always_comb begin
        rd_dat = '0;
        if (dp_rd) begin
            rd_dat = RO_MASK[dp_idx] ? reg_d[dp_idx*DATA_WIDTH +: DATA_WIDTH] : regs[dp_idx];
        end
    end
    assign bus.hrdata = rd_dat;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_OKAY;
            dp_wr    <= 1'b0;
            dp_rd    <= 1'b0;
            dp_idx   <= '0;
            dp_off   <= '0;
            dp_size  <= '0;
            wr_pulse <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            // Commit the write data phase ending at this edge; only addressed lanes change
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int b = 0; b < BW; b++) begin
                    if (dp_wr && (dp_idx == IW'(r)) && (b >= int'(dp_off)) &&
                        (b < int'(dp_off) + (1 << dp_size))) begin
                        regs[r][8*b +: 8] <= bus.hwdata[8*b +: 8];
                    end
                end
            end
            wr_pulse <= dp_wr ? (NUM_REGS'(1) << dp_idx) : '0;

            dp_wr <= 1'b0;
            dp_rd <= 1'b0;
            case (state)
                ST_ERR1: state <= ST_ERR2;
                default: begin
                    state <= ST_OKAY;
                    if (capture) begin
                        if (a_err) begin
                            state <= ST_ERR1;
                        end else begin
                            dp_wr   <= bus.hwrite;
                            dp_rd   <= !bus.hwrite;
                            dp_idx  <= a_idx[IW-1:0];
                            dp_off  <= a_off;
                            dp_size <= bus.hsize;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_reg_slave.sv
// Self-checking bench for ahb_reg_slave against a transfer-level register model.
module tb_ahb_reg_slave;
    logic         hclk = 1'b0;
    logic         hresetn = 1'b0;
    logic [127:0] reg_d = '0;
    logic [127:0] reg_q;
    logic [3:0]   wr_pulse;

    int checks = 0;
    int passes = 0;

    logic [31:0] mdl [4];

    ahb_reg_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    ahb_reg_slave #(
        .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(4), .RO_MASK(4'b0001)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .bus      (bus),
        .reg_d    (reg_d),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

    always #5 hclk = ~hclk;

    function automatic bit m_err(bit wr, logic [7:0] a, logic [2:0] sz);
        int idx = int'(a) / 4;
        if (idx >= 4) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        if ((int'(a) % (1 << sz)) != 0) return 1'b1;
        if (wr && idx == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_write(logic [7:0] a, logic [2:0] sz, logic [31:0] wd);
        int idx = int'(a) / 4;
        int off = int'(a) % 4;
        for (int b = off; b < off + (1 << sz); b++) mdl[idx][8*b +: 8] = wd[8*b +: 8];
    endfunction

    function automatic logic [31:0] m_read(logic [7:0] a);
        int idx = int'(a) / 4;
        return (idx == 0) ? reg_d[31:0] : mdl[idx];
    endfunction

    function automatic logic [127:0] m_q();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic drive_idle();
        bus.hsel_x = 1'b0; bus.htrans = 2'd0; bus.hwrite = 1'b0;
        bus.haddr = '0; bus.hsize = 3'd2; bus.hready_in = 1'b1;
    endtask

    task automatic drive_addr(bit wr, logic [7:0] a, logic [2:0] sz);
        bus.hsel_x = 1'b1; bus.htrans = 2'd2; bus.hwrite = wr;
        bus.haddr = a; bus.hsize = sz; bus.hready_in = 1'b1;
    endtask

    // One complete transfer followed by IDLE, checked against the model
    task automatic do_xfer(bit wr, logic [7:0] a, logic [2:0] sz, logic [31:0] wd, string tag);
        bit e = m_err(wr, a, sz);
        int idx = int'(a) / 4;
        logic [31:0] exp_rd;
        @(negedge hclk); drive_addr(wr, a, sz);
        @(negedge hclk); drive_idle(); bus.hwdata = wd;
        exp_rd = (!e && !wr) ? m_read(a) : 32'h0;
        checks++; if (bus.hreadyout !== !e) $display("FAIL %s hreadyout got %b want %b", tag, bus.hreadyout, !e); else passes++;
        checks++; if (bus.hresp !== e) $display("FAIL %s hresp got %b want %b", tag, bus.hresp, e); else passes++;
        checks++; if (bus.hrdata !== exp_rd) $display("FAIL %s hrdata got %h want %h", tag, bus.hrdata, exp_rd); else passes++;
        if (e) begin
            @(negedge hclk);
            checks++; if ({bus.hreadyout, bus.hresp, bus.hrdata} !== {2'b11, 32'h0}) $display("FAIL %s err2 got ro=%b resp=%b rd=%h want 1 1 0", tag, bus.hreadyout, bus.hresp, bus.hrdata); else passes++;
            @(negedge hclk);
            checks++; if ({bus.hreadyout, bus.hresp, wr_pulse} !== {2'b10, 4'b0}) $display("FAIL %s after-err got ro=%b resp=%b pulse=%b want 1 0 0", tag, bus.hreadyout, bus.hresp, wr_pulse); else passes++;
        end else begin
            if (wr) m_write(a, sz, wd);
            @(negedge hclk);
            checks++; if (wr_pulse !== (wr ? 4'(1 << idx) : 4'b0)) $display("FAIL %s wr_pulse got %b want %b", tag, wr_pulse, wr ? 4'(1 << idx) : 4'b0); else passes++;
        end
        checks++; if (reg_q !== m_q()) $display("FAIL %s reg_q got %h want %h", tag, reg_q, m_q()); else passes++;
    endtask

    task automatic test_reset();
        drive_idle(); bus.hwdata = '0;
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        @(negedge hclk);
        checks++; if (bus.hreadyout !== 1'b1) $display("FAIL reset hreadyout got %b want 1", bus.hreadyout); else passes++;
        checks++; if (bus.hresp !== 1'b0) $display("FAIL reset hresp got %b want 0", bus.hresp); else passes++;
        checks++; if (bus.hrdata !== 32'h0) $display("FAIL reset hrdata got %h want 0", bus.hrdata); else passes++;
        checks++; if (reg_q !== '0) $display("FAIL reset reg_q got %h want 0", reg_q); else passes++;
        checks++; if (wr_pulse !== 4'b0) $display("FAIL reset wr_pulse got %b want 0", wr_pulse); else passes++;
    endtask

    task automatic test_back_to_back();
        @(negedge hclk); drive_addr(1'b1, 8'h04, 3'd2);
        @(negedge hclk); drive_addr(1'b0, 8'h04, 3'd2); bus.hwdata = 32'hDEADBEEF;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL b2b wdata-phase resp got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
        @(negedge hclk); drive_idle();
        mdl[1] = 32'hDEADBEEF;
        checks++; if (bus.hrdata !== 32'hDEADBEEF) $display("FAIL b2b hrdata got %h want deadbeef", bus.hrdata); else passes++;
        checks++; if (wr_pulse !== 4'b0010) $display("FAIL b2b wr_pulse got %b want 0010", wr_pulse); else passes++;
        checks++; if (reg_q[63:32] !== 32'hDEADBEEF) $display("FAIL b2b reg_q1 got %h want deadbeef", reg_q[63:32]); else passes++;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL b2b rdata-phase resp got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
        @(negedge hclk);
        checks++; if (wr_pulse !== 4'b0) $display("FAIL b2b pulse-clear got %b want 0", wr_pulse); else passes++;
        checks++; if (bus.hrdata !== 32'h0) $display("FAIL b2b idle hrdata got %h want 0", bus.hrdata); else passes++;
    endtask

    task automatic test_byte_write();
        do_xfer(1'b1, 8'h08, 3'd2, 32'h11223344, "byte_init");
        do_xfer(1'b1, 8'h09, 3'd0, 32'h5555AA55, "byte_wr");
        checks++; if (reg_q[95:64] !== 32'h1122AA44) $display("FAIL byte reg2 got %h want 1122aa44", reg_q[95:64]); else passes++;
        do_xfer(1'b1, 8'h0E, 3'd1, 32'hBEEF0000, "half_wr");
        do_xfer(1'b0, 8'h0C, 3'd2, 32'h0, "half_rd");
    endtask

    task automatic test_read_only();
        reg_d[31:0] = 32'h0000005A;
        do_xfer(1'b1, 8'h00, 3'd2, 32'hFFFFFFFF, "ro_write");
        do_xfer(1'b0, 8'h00, 3'd2, 32'h0, "ro_read");
    endtask

    task automatic test_errors();
        do_xfer(1'b0, 8'h10, 3'd2, 32'h0, "err_index");
        do_xfer(1'b0, 8'h04, 3'd3, 32'h0, "err_size");
        do_xfer(1'b0, 8'h06, 3'd2, 32'h0, "err_align");
        do_xfer(1'b1, 8'h05, 3'd1, 32'h12345678, "err_wr_align");
    endtask

    task automatic test_no_transfer();
        @(negedge hclk); drive_addr(1'b1, 8'h04, 3'd2); bus.htrans = 2'd0;
        @(negedge hclk); drive_addr(1'b1, 8'h08, 3'd2); bus.hready_in = 1'b0; bus.hwdata = 32'hCAFEF00D;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL idle_sel resp got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
        @(negedge hclk); drive_idle(); bus.hwdata = 32'h0BADF00D;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL nordy resp got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
        checks++; if (wr_pulse !== 4'b0) $display("FAIL idle_sel wr_pulse got %b want 0", wr_pulse); else passes++;
        @(negedge hclk);
        checks++; if (wr_pulse !== 4'b0) $display("FAIL nordy wr_pulse got %b want 0", wr_pulse); else passes++;
        checks++; if (reg_q !== m_q()) $display("FAIL notrans reg_q got %h want %h", reg_q, m_q()); else passes++;
    endtask

    task automatic test_err_pipeline();
        // Address phase during ERR1 is dropped
        @(negedge hclk); drive_addr(1'b1, 8'h00, 3'd2);
        @(negedge hclk); drive_addr(1'b1, 8'h04, 3'd2); bus.hwdata = 32'h0;
        @(negedge hclk); drive_idle(); bus.hwdata = 32'hFFFFFFFF;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b11) $display("FAIL err1_ignore err2 got ro=%b resp=%b want 1 1", bus.hreadyout, bus.hresp); else passes++;
        @(negedge hclk);
        checks++; if (wr_pulse !== 4'b0) $display("FAIL err1_ignore wr_pulse got %b want 0", wr_pulse); else passes++;
        checks++; if (reg_q !== m_q()) $display("FAIL err1_ignore reg_q got %h want %h", reg_q, m_q()); else passes++;
        // New transfer accepted during ERR2
        drive_addr(1'b0, 8'h11, 3'd0);
        @(negedge hclk); drive_idle();
        @(negedge hclk); drive_addr(1'b1, 8'h0C, 3'd2);
        @(negedge hclk); drive_idle(); bus.hwdata = 32'h600DCAFE;
        m_write(8'h0C, 3'd2, 32'h600DCAFE);
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL err2_cap resp got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
        @(negedge hclk);
        checks++; if (wr_pulse !== 4'b1000) $display("FAIL err2_cap wr_pulse got %b want 1000", wr_pulse); else passes++;
        checks++; if (reg_q !== m_q()) $display("FAIL err2_cap reg_q got %h want %h", reg_q, m_q()); else passes++;
    endtask

    task automatic test_reset_mid();
        @(negedge hclk); drive_addr(1'b0, 8'h10, 3'd2);
        @(negedge hclk); drive_idle();
        hresetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL rst_err1 resp got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
        checks++; if (reg_q !== '0) $display("FAIL rst_err1 reg_q got %h want 0", reg_q); else passes++;
        @(negedge hclk); hresetn = 1'b1;
        @(negedge hclk);
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL rst_err1 release got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
        drive_addr(1'b1, 8'h04, 3'd2);
        @(negedge hclk); drive_idle(); bus.hwdata = 32'h12345678;
        hresetn = 1'b0;
        @(negedge hclk); hresetn = 1'b1;
        @(negedge hclk);
        checks++; if (wr_pulse !== 4'b0) $display("FAIL rst_wr wr_pulse got %b want 0", wr_pulse); else passes++;
        checks++; if (reg_q !== '0) $display("FAIL rst_wr reg_q got %h want 0", reg_q); else passes++;
        checks++; if ({bus.hreadyout, bus.hresp} !== 2'b10) $display("FAIL rst_wr resp got ro=%b resp=%b want 1 0", bus.hreadyout, bus.hresp); else passes++;
    endtask

    task automatic test_random();
        reg_d = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 60; n++) begin
            bit          wr = 1'($urandom_range(0, 1));
            logic [7:0]  a  = 8'($urandom_range(0, 19));
            logic [2:0]  sz = 3'($urandom_range(0, 3));
            logic [31:0] wd = $urandom;
            do_xfer(wr, a, sz, wd, "random");
        end
    endtask

    initial begin
        drive_idle();
        bus.hwdata = '0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        test_reset();
        test_back_to_back();
        test_byte_write();
        test_read_only();
        test_errors();
        test_no_transfer();
        test_err_pipeline();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ahb_reg_slave.md
AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

Parameters
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, HADDR width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, HWDATA/HRDATA and register width; legal values 8, 16, 32.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of registers, range 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have parameter RO_MASK, NUM_REGS bits, default 'b0001; bit i=1 makes register i read-only.

Interface
REQ-005 SHALL have port hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port hresetn, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port hsel_x, input, 1, slave select.
REQ-008 SHALL have port haddr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have ports htrans (input, 2), hwrite (input, 1) and hsize (input, 3), the AHB transfer controls.
REQ-010 SHALL have port hwdata, input, DATA_WIDTH, write data, valid in the data phase.
REQ-011 SHALL have port hready_in, input, 1, bus HREADY.
REQ-012 SHALL have port reg_d, input, NUM_REGS*DATA_WIDTH, hardware values of read-only registers; slice i belongs to register i.
REQ-013 SHALL have port hrdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have ports hreadyout (output, 1) and hresp (output, 1; 0=OKAY, 1=ERROR).
REQ-015 SHALL have port reg_q, output, NUM_REGS*DATA_WIDTH, stored RW register contents.
REQ-016 SHALL have port wr_pulse, output, NUM_REGS, one-cycle strobe per register write.

Function
REQ-017 SHALL capture an address phase only when hsel_x=1, hready_in=1 and htrans is NONSEQ(2) or SEQ(3); IDLE/BUSY get a zero-wait OKAY.
REQ-018 SHALL decode index = haddr >> log2(DATA_WIDTH/8) and byte offset = the low log2(DATA_WIDTH/8) bits.
REQ-019 SHALL flag error at capture if any holds: index >= NUM_REGS; hsize > log2(DATA_WIDTH/8); offset not aligned to 2^hsize; hwrite=1 with RO_MASK[index]=1.
REQ-020 SHALL run FSM OKAY -> ERR1 -> ERR2 -> OKAY; an errored capture enters ERR1 on the next edge.
REQ-021 ERR1: hreadyout=0, hresp=1; ERR2: hreadyout=1, hresp=1; OKAY: hreadyout=1, hresp=0 (zero wait states).
REQ-022 SHALL ignore any address phase while in ERR1; in ERR2 SHALL capture a new transfer per REQ-017.
REQ-023 SHALL write the error-free write data phase at the edge ending it: only byte lanes offset..offset+2^hsize-1 of register index take hwdata lanes (little-endian); other bytes keep their value.
REQ-024 SHALL drive wr_pulse[index]=1 for exactly the cycle after that write edge; errored writes give no pulse and no change.
REQ-025 SHALL drive hrdata combinationally in a read data phase: reg_d slice if RO_MASK[index]=1, else stored value; 0 in all other cycles, including errored reads.
REQ-026 A read whose address phase overlaps the preceding write's data phase to the same register SHALL return the newly written value.
REQ-027 A master cancelling to IDLE in ERR2 SHALL be accepted; no stale write is performed.

Reset
REQ-028 hresetn=0 SHALL immediately force FSM=OKAY, all registers and reg_q to 0, wr_pulse=0, hreadyout=1, hresp=0, pending data phase discarded.
REQ-029 Reset asserted mid-ERR1 or mid-write data phase SHALL leave no write and no error response after release.

Verification
REQ-030 Write 0xDEADBEEF to 0x04 (hsize=2) then read 0x04 back-to-back -> reg_q slice 1 = 0xDEADBEEF, wr_pulse[1] for one cycle, hrdata=0xDEADBEEF, hresp=0 throughout.
REQ-031 Byte write 0xAA to 0x09 over reg2=0x11223344 -> reg2=0x1122AA44.
REQ-032 Write to 0x00 (RO) -> hreadyout 0 then 1 with hresp=1 both cycles, reg unchanged, no wr_pulse; read 0x00 with reg_d slice 0=0x5A -> hrdata=0x5A.
REQ-033 Read 0x10 (index 4), hsize=3 at 0x04, and hsize=2 at 0x06 -> each gives two-cycle ERROR, hrdata=0.
REQ-034 htrans=IDLE with hsel_x=1, and htrans=NONSEQ with hready_in=0 -> OKAY, no write, no FSM change.
REQ-035 hresetn low during ERR1 -> hreadyout=1, hresp=0 immediately; all reg_q=0.
